weight_index_sequencer: RTL and testbench
=========================================

# weight_index_sequencer

Avalon-MM slave controller that autonomously steps the 13-bit weight-memory index for the MNIST classifier datapath, replacing one-CSR-write-per-weight sequencing from the Nios II. Software programs a base index and a count, then issues start. The block then emits consecutive indices to the weight fetch datapath over a valid/ready handshake and reports completion by status bit and interrupt.

## Interface
- INDEX_W, 13, width of weight index (matches weight memory address)
- CNT_W, 14, width of count register (allows a full 8192-entry sweep)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset; one clock, sync active-high reset
- address  in  2  CSR word offset
- chipselect  in  1  Avalon slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  CSR write data
- readdata  out  32  CSR read data, combinational (zero wait-state read), unused bits 0
- idx_out  out  INDEX_W  current weight index to datapath
- idx_valid  out  1  idx_out is valid
- idx_ready  in  1  datapath accepts idx_out this cycle
- idx_last  out  1  qualifies the final index of the sweep (valid only with idx_valid)
- irq  out  1  level interrupt = done & irq_en

## Operation
- CSR map (write = chipselect & ~write_n):
  - 0 BASE: RW [12:0] first index
  - 1 COUNT: RW [13:0] number of indices; 0 = empty sweep
  - 2 CTRL: write bit0 start, bit1 abort, bit2 clear done, bit3 irq_en (stored). Read bit0 busy, bit1 done, bit3 irq_en
  - 3 PROGRESS: RO [13:0] beats accepted in current/last sweep
- BASE/COUNT writes while busy are ignored; values are latched into working registers at start.
- States: IDLE, RUN.
  - IDLE→RUN on start with COUNT≠0: idx←BASE, remaining←COUNT, progress←0, done←0.
  - start with COUNT=0 in IDLE: stays IDLE, done←1 (sets irq if enabled).
  - In RUN: each cycle with idx_valid & idx_ready: idx←idx+1 modulo 2^INDEX_W (8191 wraps to 0), remaining−1, progress+1.
  - Accept with remaining=1 → IDLE, done←1.
  - abort in RUN → IDLE, done stays 0, progress holds.
- start while busy is ignored. Abort in IDLE has no effect.
- Same-cycle write with start and abort: abort wins in RUN. In IDLE, start is taken.
- Clear-done (bit2) clears done. Start also clears done.
- idx_valid = (state==RUN). idx_last = RUN & remaining==1.
- idx_out holds stable while idx_valid & ~idx_ready. In IDLE it holds the last value.

## Timing
- Reset values: idx_out 0, idx_valid 0, idx_last 0, irq 0, readdata reflects zeroed CSRs. BASE, COUNT, progress, done and irq_en are all 0. State IDLE.
- Start write in cycle N → idx_valid=1 and busy=1 from cycle N+1, with idx_out=BASE.
- Throughput is one index per cycle while idx_ready=1. No bubbles between beats.
- Final accept in cycle M → idx_valid=0, busy=0, done=1, irq (if enabled) in cycle M+1.
- Abort write in cycle N → idx_valid=0 from N+1. A beat accepted in cycle N is counted.
- Reset asserted mid-sweep returns all state to reset values on the next edge. No partial-beat recovery.
- CSR reads are combinational on address. A read in the same cycle as a state change returns the pre-edge value.

## Structure
- Shared package weight_index_pkg: INDEX_W/CNT_W defaults, CSR offsets (REG_BASE=0, REG_COUNT=1, REG_CTRL=2, REG_PROGRESS=3), CTRL bit positions, state enum {IDLE, RUN}.
- Single module. No sub-module is needed. The CSR decode and the counter FSM fit together in one file.

## Test plan
- BASE=100, COUNT=5, start, idx_ready=1 → idx_out 100..104 on consecutive cycles, idx_last only on 104, done=1 and PROGRESS=5 one cycle later.
- BASE=8190, COUNT=4, ready tied high → indices 8190, 8191, 0, 1 (wrap), done set.
- BASE=10, COUNT=3, ready toggling 1,0,0,1,… → idx_out held stable during stalls, exactly 3 accepts, no skipped or duplicated index.
- COUNT=0, irq_en=1, start → idx_valid never asserts, done=1 and irq=1 next cycle. Clear-done → irq=0.
- BASE=0, COUNT=100, abort after 7 accepts. Writing BASE=50 while busy → idx_valid drops next cycle, done=0, PROGRESS=7, BASE still reads 0.
- Assert reset mid-sweep → all outputs return to reset values. A subsequent start with BASE=5, COUNT=1 yields a single beat at 5 with idx_last=1.

Source files
------------

// File: rtl/weight_index_pkg.sv
// Shared widths, CSR map and FSM state type for the weight index sequencer.
package weight_index_pkg;

    localparam int unsigned INDEX_W = 13;
    localparam int unsigned CNT_W   = 14;
    localparam int unsigned ADDR_W  = 2;
    localparam int unsigned DATA_W  = 32;

    localparam logic [ADDR_W-1:0] REG_BASE     = 2'd0;
    localparam logic [ADDR_W-1:0] REG_COUNT    = 2'd1;
    localparam logic [ADDR_W-1:0] REG_CTRL     = 2'd2;
    localparam logic [ADDR_W-1:0] REG_PROGRESS = 2'd3;

    // CTRL write bits; irq_en shares its position on read
    localparam int unsigned CTRL_START    = 0;
    localparam int unsigned CTRL_ABORT    = 1;
    localparam int unsigned CTRL_CLR_DONE = 2;
    localparam int unsigned CTRL_IRQ_EN   = 3;

    // CTRL read status bits
    localparam int unsigned STAT_BUSY = 0;
    localparam int unsigned STAT_DONE = 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/weight_index_sequencer.sv
// Avalon-MM programmable sweep of consecutive weight-memory indices,
// streamed over valid/ready with done status and level interrupt.
module weight_index_sequencer
    import weight_index_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [DATA_W-1:0]   writedata,
    output logic [DATA_W-1:0]   readdata,
    output logic [INDEX_W-1:0]  idx_out,
    output logic                idx_valid,
    input  logic                idx_ready,
    output logic                idx_last,
    output logic                irq
);

    state_e              state_q, state_d;
    logic [INDEX_W-1:0]  base_q;
    logic [CNT_W-1:0]    count_q;
    logic                irq_en_q;
    logic [INDEX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [CNT_W-1:0]    prog_q, prog_d;
    logic                done_q, done_d;

    logic wr, ctrl_wr, start, abort, accept, busy;
    logic unused_wd;

    assign wr        = chipselect & ~write_n;
    assign ctrl_wr   = wr & (address == REG_CTRL);
    assign start     = ctrl_wr & writedata[CTRL_START];
    assign abort     = ctrl_wr & writedata[CTRL_ABORT];
    assign busy      = (state_q == RUN);
    assign accept    = busy & idx_ready;
    assign unused_wd = ^writedata[DATA_W-1:CNT_W];

    // State and working counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            prog_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            prog_q  <= prog_d;
            done_q  <= done_d;
        end
    end

    // Next-state: clear-done is applied first so a same-write start can override it
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        prog_d  = prog_q;
        done_d  = done_q;
        if (ctrl_wr && writedata[CTRL_CLR_DONE]) begin
            done_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    prog_d = '0;
                    if (count_q != '0) begin
                        state_d = RUN;
                        idx_d   = base_q;
                        rem_d   = count_q;
                        done_d  = 1'b0;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    idx_d  = idx_q + INDEX_W'(1);
                    rem_d  = rem_q - CNT_W'(1);
                    prog_d = prog_q + CNT_W'(1);
                end
                if (abort) begin
                    state_d = IDLE;
                end else if (accept && (rem_q == CNT_W'(1))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    // Software-visible configuration; BASE/COUNT frozen while a sweep runs
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q   <= '0;
            count_q  <= '0;
            irq_en_q <= 1'b0;
        end else begin
            if (wr && !busy && (address == REG_BASE)) begin
                base_q <= writedata[INDEX_W-1:0];
            end
            if (wr && !busy && (address == REG_COUNT)) begin
                count_q <= writedata[CNT_W-1:0];
            end
            if (ctrl_wr) begin
                irq_en_q <= writedata[CTRL_IRQ_EN];
            end
        end
    end

    // Zero wait-state CSR read mux
    always_comb begin
        readdata = '0;
        case (address)
            REG_BASE:     readdata = DATA_W'(base_q);
            REG_COUNT:    readdata = DATA_W'(count_q);
            REG_CTRL: begin
                readdata[STAT_BUSY]   = busy;
                readdata[STAT_DONE]   = done_q;
                readdata[CTRL_IRQ_EN] = irq_en_q;
            end
            REG_PROGRESS: readdata = DATA_W'(prog_q);
            default:      readdata = '0;
        endcase
    end

    assign idx_out   = idx_q;
    assign idx_valid = busy;
    assign idx_last  = busy & (rem_q == CNT_W'(1));
    assign irq       = done_q & irq_en_q;

endmodule

// File: tb/tb_weight_index_sequencer.sv
// Randomized bench for weight_index_sequencer against a queue-based sweep model.
module tb_weight_index_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [12:0] idx_out;
    logic        idx_valid;
    logic        idx_ready;
    logic        idx_last;
    logic        irq;

    weight_index_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .idx_out    (idx_out),
        .idx_valid  (idx_valid),
        .idx_ready  (idx_ready),
        .idx_last   (idx_last),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ready_mode = 0;

    // Reference model: the sweep is the queue of indices still to be delivered
    int q[$];
    bit m_busy, m_done, m_irq_en;
    int m_base, m_count, m_prog, m_idx;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_base);
            2'd1:    return 32'(m_count);
            2'd2:    return {28'd0, m_irq_en, 1'b0, m_done, m_busy};
            default: return 32'(m_prog);
        endcase
    endfunction

    task automatic model_step();
        bit pre_busy, acc, wr, abort_now;
        pre_busy = m_busy;
        if (reset) begin
            q.delete();
            m_busy = 0; m_done = 0; m_irq_en = 0;
            m_base = 0; m_count = 0; m_prog = 0; m_idx = 0;
            return;
        end
        wr        = chipselect && !write_n;
        acc       = pre_busy && idx_ready;
        abort_now = wr && address == 2'd2 && writedata[1] && pre_busy;
        if (acc) begin
            void'(q.pop_front());
            m_prog++;
            m_idx = (m_idx + 1) % 8192;
        end
        if (wr && address == 2'd2) begin
            if (writedata[2]) m_done = 0;
            m_irq_en = writedata[3];
            if (abort_now) begin
                m_busy = 0;
                q.delete();
            end else if (!pre_busy && writedata[0]) begin
                m_prog = 0;
                if (m_count == 0) begin
                    m_done = 1;
                end else begin
                    m_done = 0;
                    q.delete();
                    for (int i = 0; i < m_count; i++) q.push_back((m_base + i) % 8192);
                    m_idx  = m_base;
                    m_busy = 1;
                end
            end
        end
        if (pre_busy && !abort_now && acc && q.size() == 0) begin
            m_busy = 0;
            m_done = 1;
        end
        if (wr && !pre_busy && address == 2'd0) m_base  = int'(writedata[12:0]);
        if (wr && !pre_busy && address == 2'd1) m_count = int'(writedata[13:0]);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check_eq("valid", 32'(idx_valid), 32'(m_busy));
        if (m_busy) check_eq("idx", 32'(idx_out), 32'(q[0]));
        else        check_eq("idx_hold", 32'(idx_out), 32'(m_idx));
        check_eq("last", 32'(idx_last), 32'(m_busy && q.size() == 1));
        check_eq("irq", 32'(irq), 32'(m_done && m_irq_en));
        check_eq("rd", readdata, exp_rd(address));
        case (ready_mode)
            0:       idx_ready = 1'b1;
            1:       idx_ready = (cyc % 3 == 0);
            2:       idx_ready = 1'($urandom_range(0, 1));
            default: idx_ready = 1'b0;
        endcase
    endtask

    task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = $urandom;
    endtask

    task automatic run_idle(input int budget);
        for (int i = 0; i < budget && m_busy; i++) tick();
        check_eq("sweep_end", 32'(idx_valid), 32'd0);
    endtask

    task automatic read_expect(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check_eq(tag, readdata, exp);
    endtask

    initial begin
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = '0;
        idx_ready  = 1'b0;
        ready_mode = 3;
        tick();
        tick();
        reset = 1'b0;
        read_expect("rst_ctrl", 2'd2, 32'd0);
        read_expect("rst_base", 2'd0, 32'd0);

        // Basic sweep
        ready_mode = 0;
        csr_write(2'd0, 32'd100);
        csr_write(2'd1, 32'd5);
        csr_write(2'd2, 32'h1);
        check_eq("first_idx", 32'(idx_out), 32'd100);
        run_idle(20);
        read_expect("prog5", 2'd3, 32'd5);
        read_expect("done1", 2'd2, 32'h2);

        // Index wrap at 8191
        csr_write(2'd0, 32'd8190);
        csr_write(2'd1, 32'd4);
        csr_write(2'd2, 32'h1);
        run_idle(20);
        check_eq("wrap_idx", 32'(idx_out), 32'd2);

        // Stalls via ready pattern 1,0,0,1,...
        ready_mode = 1;
        csr_write(2'd0, 32'd10);
        csr_write(2'd1, 32'd3);
        csr_write(2'd2, 32'h1);
        run_idle(40);
        read_expect("prog3", 2'd3, 32'd3);

        // Empty sweep with interrupt, then clear-done
        ready_mode = 0;
        csr_write(2'd1, 32'd0);
        csr_write(2'd2, 32'h9);
        check_eq("empty_irq", 32'(irq), 32'd1);
        csr_write(2'd2, 32'hC);
        check_eq("clr_irq", 32'(irq), 32'd0);

        // Abort after 7 accepts, with a BASE write ignored while busy
        csr_write(2'd0, 32'd0);
        csr_write(2'd1, 32'd100);
        csr_write(2'd2, 32'h1);
        for (int i = 0; i < 50 && m_prog < 5; i++) tick();
        csr_write(2'd0, 32'd50);
        ready_mode = 3;
        tick();
        csr_write(2'd2, 32'h2);
        check_eq("abort_valid", 32'(idx_valid), 32'd0);
        read_expect("abort_prog", 2'd3, 32'd7);
        read_expect("abort_ctrl", 2'd2, 32'd0);
        read_expect("abort_base", 2'd0, 32'd0);

        // Reset mid-sweep, then a single-beat sweep
        ready_mode = 2;
        csr_write(2'd1, 32'd20);
        csr_write(2'd2, 32'h9);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("rst_valid", 32'(idx_valid), 32'd0);
        check_eq("rst_idx", 32'(idx_out), 32'd0);
        ready_mode = 3;
        csr_write(2'd0, 32'd5);
        csr_write(2'd1, 32'd1);
        csr_write(2'd2, 32'h1);
        check_eq("single_last", 32'(idx_last), 32'd1);
        check_eq("single_idx", 32'(idx_out), 32'd5);
        ready_mode = 0;
        tick();
        run_idle(10);

        // Random CSR traffic and backpressure
        ready_mode = 2;
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 9))
                0: csr_write(2'd0, ($urandom_range(0, 1) != 0) ? 32'($urandom_range(8184, 8191))
                                                               : 32'($urandom_range(0, 8191)));
                1: csr_write(2'd1, 32'($urandom_range(0, 12)));
                2: csr_write(2'd2, {28'd0, 1'($urandom_range(0, 1)), 3'b001});
                3: csr_write(2'd2, 32'($urandom_range(0, 15)));
                4: csr_write(2'd2, 32'h4);
                default: begin
                    address = 2'($urandom_range(0, 3));
                    tick();
                end
            endcase
        end
        ready_mode = 0;
        run_idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
